instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage upstream of the 16-bit RISC datapath/control pair.
//  - Owns the fetch PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
//  - Buffers returned instructions with their PCs in a DEPTH-entry prefetch FIFO.
//  - Presents the FIFO head to decode over valid/ready.
//  - On jump/beq/bne redirect from the datapath: flushes everything and restarts fetch at the target.
// PARAMETERS
//  ADDR_W    16       PC / imem address width
//  DATA_W    16       instruction width
//  DEPTH     4        prefetch FIFO entries; power of 2, >=2
//  RESET_PC  16'h0000 first fetch address after reset
//  PC_INC    2        byte increment per sequential fetch
// PORTS
//  clk          in   1                   rising-edge clock
//  rst_n        in   1                   synchronous active-low reset
//  imem_req     out  1                   fetch request valid
//  imem_addr    out  ADDR_W              fetch address; held stable while imem_req && !imem_gnt
//  imem_gnt     in   1                   request accepted this cycle
//  imem_rvalid  in   1                   read data valid; earliest the cycle after gnt
//  imem_rdata   in   DATA_W              instruction word
//  instr_valid  out  1                   FIFO head valid
//  instr_ready  in   1                   decode accepts head
//  instr        out  DATA_W              head instruction; opcode = instr[15:12]
//  instr_pc     out  ADDR_W              PC of head instruction
//  redirect     in   1                   taken jump/branch; 1-cycle pulse
//  redirect_pc  in   ADDR_W              target PC
//  occupancy    out  $clog2(DEPTH+1)     FIFO fill level
// BEHAVIOUR
//  Reset (rst_n low at posedge)
//   - fetch_pc=RESET_PC, FIFO empty, state IDLE, drop=0.
//   - Outputs: imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, occupancy=0.
//   - imem_rvalid is ignored until the first post-reset grant.
//  FSM
//   - IDLE: go to REQ when occupancy+outstanding < DEPTH.
//   - REQ: imem_req=1, imem_addr=fetch_pc.
//     - On gnt: fetch_pc += PC_INC (mod 2^ADDR_W); go to WAIT.
//   - WAIT: imem_req=0; at most one request outstanding.
//     - On rvalid with drop=0: push {imem_rdata, issued addr}.
//     - On rvalid with drop=1: discard the data and clear drop.
//     - Then go to REQ if space remains after the push, else IDLE.
//  Credit rule
//   - A request is issued only if a free slot exists for its response, so a push never meets a full FIFO.
//  Output
//   - instr_valid = (occupancy != 0); instr and instr_pc are the head entry, registered.
//   - Pop on instr_valid && instr_ready.
//   - Push and pop in the same cycle leave occupancy unchanged.
//   - Response at cycle N gives instr_valid at N+1 (FIFO empty, no redirect).
//  Redirect (highest priority, takes effect next cycle)
//   - FIFO flushed: occupancy=0 and instr_valid=0 next cycle; a same-cycle pop is void.
//   - fetch_pc=redirect_pc.
//   - IDLE or REQ without gnt: next state REQ with imem_addr=redirect_pc; the un-granted request is abandoned.
//   - REQ with gnt in the same cycle: go to WAIT with drop=1; fetch_pc=redirect_pc, not the incremented value.
//   - WAIT without rvalid: drop=1 and stay in WAIT.
//   - WAIT with rvalid in the same cycle: data discarded, drop stays 0, go to REQ.
//  Arithmetic
//   - PC increment wraps modulo 2^ADDR_W.
//   - redirect_pc is used as-is; the LSB is not checked.
// TESTING
//  1. rst_n=0 for 3 clks, then release.
//     -> All outputs 0 during reset; imem_req=1, imem_addr=0x0000 on the first cycle after release.
//  2. Memory with gnt immediate and rvalid 1 cycle later; instr_ready=1.
//     -> instr_pc sequence 0x0000, 0x0002, 0x0004, ... with imem_rdata in order; no gaps beyond the FSM cadence.
//  3. instr_ready=0.
//     -> Exactly 4 fetches (0x0000..0x0006); occupancy=4; imem_req stays 0.
//     -> After instr_ready=1, the next fetch is 0x0008.
//  4. redirect to 0x0100 while WAIT on 0x0004.
//     -> The 0x0004 response is dropped; the next instr_pc is 0x0100; occupancy is 0 the cycle after redirect.
//  5a. redirect coincident with gnt.
//     -> The following response is dropped; the next fetch addr is the target.
//  5b. redirect coincident with rvalid.
//     -> The data is discarded; REQ to the target the next cycle.
//  6. redirect_pc=0xFFFE.
//     -> Fetches 0xFFFE then 0x0000; instr_pc is reported correctly for both.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, fetches one word at a time over
// a req/gnt/rvalid handshake and buffers the responses with their PCs in a
// small prefetch FIFO. The FIFO head goes to decode over valid/ready. A
// redirect flushes the FIFO and restarts fetch at the target. A request that
// is already granted when the redirect arrives is marked with drop so that
// its late response is thrown away.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [DATA_W-1:0]          imem_rdata,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [DATA_W-1:0]          instr,
    output logic [ADDR_W-1:0]          instr_pc,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0] issued_pc_reg, issued_pc_next;
    logic              drop_reg, drop_next;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0]  occ_reg, occ_next;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic              push, pop, has_space;

    // FIFO bookkeeping. A redirect voids both the push and the pop of the
    // same cycle, because the whole FIFO is flushed anyway.
    always_comb begin
        push = (state_reg == ST_WAIT) && imem_rvalid && !drop_reg && !redirect;
        pop  = (occ_reg != '0) && instr_ready && !redirect;
        occ_next = occ_reg;
        if (redirect) begin
            occ_next = '0;
        end else if (push && !pop) begin
            occ_next = occ_reg + OCC_W'(1);
        end else if (pop && !push) begin
            occ_next = occ_reg - OCC_W'(1);
        end
        // At most one request is outstanding, and only in WAIT. Checking the
        // post-push level when leaving WAIT guarantees a slot for the next
        // response, so a push never finds the FIFO full.
        has_space = occ_next < OCC_W'(DEPTH);
    end

    // Fetch FSM: next state, fetch PC, address of the granted request, and
    // the drop flag for a response whose request a redirect made stale.
    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        issued_pc_next = issued_pc_reg;
        drop_next      = drop_reg;
        case (state_reg)
            ST_IDLE: begin
                if (redirect) begin
                    state_next    = ST_REQ;
                    fetch_pc_next = redirect_pc;
                end else if (occ_reg < OCC_W'(DEPTH)) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_next     = ST_WAIT;
                    issued_pc_next = fetch_pc_reg;
                    if (redirect) begin
                        fetch_pc_next = redirect_pc;
                        drop_next     = 1'b1;
                    end else begin
                        fetch_pc_next = fetch_pc_reg + ADDR_W'(PC_INC);
                    end
                end else if (redirect) begin
                    // The un-granted request is abandoned. The next cycle
                    // presents the target address instead.
                    fetch_pc_next = redirect_pc;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                    if (imem_rvalid) begin
                        drop_next  = 1'b0;
                        state_next = ST_REQ;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    drop_next  = 1'b0;
                    state_next = has_space ? ST_REQ : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, PC and FIFO storage registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            fetch_pc_reg  <= RESET_PC;
            issued_pc_reg <= '0;
            drop_reg      <= 1'b0;
            occ_reg       <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            issued_pc_reg <= issued_pc_next;
            drop_reg      <= drop_next;
            occ_reg       <= occ_next;
            if (redirect) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    data_mem[wr_ptr_reg] <= imem_rdata;
                    pc_mem[wr_ptr_reg]   <= issued_pc_reg;
                    wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
            end
        end
    end

    assign imem_req    = (state_reg == ST_REQ);
    assign imem_addr   = imem_req ? fetch_pc_reg : '0;
    assign instr_valid = (occ_reg != '0);
    assign instr       = data_mem[rd_ptr_reg];
    assign instr_pc    = pc_mem[rd_ptr_reg];
    assign occupancy   = occ_reg;

endmodule
